dp_mem_write_first: RTL and testbench



---
 rtl/dp_mem_write_first_port.sv | 62 ++++++
 rtl/dp_mem_write_first.sv | 75 +++++++
 tb/tb_dp_mem_write_first.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dp_mem_write_first_port.sv
// One port of the write-first dual-port RAM: read register with same-port and
// cross-port bypass, plus an optional second output register stage.
module dp_mem_write_first_port #(
  parameter int WIDTH   = 32,
  parameter int OUTREG  = 0,
  // 1 when the other port's data wins a same-address dual write
  parameter int XWINS   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic [WIDTH-1:0] mem_q,
  input  logic             xwr,
  input  logic [WIDTH-1:0] xdi,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] rd_q;

  // xwr is only asserted by the top when both ports are enabled on the same address
  always_comb begin
    load_val = mem_q;
    if (we && !(xwr && (XWINS != 0))) begin
      load_val = di;
    end else if (xwr) begin
      load_val = xdi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (en) begin
      rd_q <= load_val;
    end
  end

  if (OUTREG != 0) begin : g_oreg
    logic             en_d;
    logic [WIDTH-1:0] out_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        en_d  <= 1'b0;
        out_q <= '0;
      end else begin
        en_d <= en;
        if (en_d) begin
          out_q <= rd_q;
        end
      end
    end

    assign dout = out_q;
  end else begin : g_noreg
    assign dout = rd_q;
  end

endmodule

// File: rtl/dp_mem_write_first.sv
// True dual-port, single-clock RAM with write-first behaviour on each port.
// On a same-address dual write, port B's data is stored and returned on both ports.
module dp_mem_write_first #(
  parameter int DEPTH   = 10,
  parameter int WIDTH   = 32,
  parameter int OUTREGA = 1,
  parameter int OUTREGB = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             wea,
  input  logic [DEPTH-1:0] addra,
  input  logic [WIDTH-1:0] dia,
  output logic [WIDTH-1:0] doa,
  input  logic             enb,
  input  logic             web,
  input  logic [DEPTH-1:0] addrb,
  input  logic [WIDTH-1:0] dib,
  output logic [WIDTH-1:0] dob
);

  reg [WIDTH-1:0] mem [0:2**DEPTH-1] = '{default: '0};

  logic same_addr;
  logic hit_a;
  logic hit_b;

  assign same_addr = ena && enb && (addra == addrb);
  assign hit_a     = same_addr && web;
  assign hit_b     = same_addr && wea;

  // Port B's assignment comes last so it wins a same-address dual write; rst does not gate writes
  always @(posedge clk) begin
    if (ena && wea) begin
      mem[addra] <= dia;
    end
    if (enb && web) begin
      mem[addrb] <= dib;
    end
  end

  dp_mem_write_first_port #(
    .WIDTH  (WIDTH),
    .OUTREG (OUTREGA),
    .XWINS  (1)
  ) u_port_a (
    .clk   (clk),
    .rst   (rst),
    .en    (ena),
    .we    (wea),
    .di    (dia),
    .mem_q (mem[addra]),
    .xwr   (hit_a),
    .xdi   (dib),
    .dout  (doa)
  );

  dp_mem_write_first_port #(
    .WIDTH  (WIDTH),
    .OUTREG (OUTREGB),
    .XWINS  (0)
  ) u_port_b (
    .clk   (clk),
    .rst   (rst),
    .en    (enb),
    .we    (web),
    .di    (dib),
    .mem_q (mem[addrb]),
    .xwr   (hit_b),
    .xdi   (dia),
    .dout  (dob)
  );

endmodule

// File: tb/tb_dp_mem_write_first.sv
// Directed bench: four instances (index bit1 = OUTREGA, bit0 = OUTREGB) share
// one stimulus stream; outputs are sampled 1 ns after each rising edge.
module tb_dp_mem_write_first;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena, wea, enb, web;
  logic [DEPTH-1:0] addra, addrb;
  logic [WIDTH-1:0] dia, dib;
  logic [WIDTH-1:0] doa_w [4];
  logic [WIDTH-1:0] dob_w [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dp_mem_write_first #(
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .OUTREGA (g / 2),
      .OUTREGB (g % 2)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .wea   (wea),
      .addra (addra),
      .dia   (dia),
      .doa   (doa_w[g]),
      .enb   (enb),
      .web   (web),
      .addrb (addrb),
      .dib   (dib),
      .dob   (dob_w[g])
    );
  end

  task automatic step(input logic r,
                      input logic a_en, input logic a_we, input logic [DEPTH-1:0] a_addr,
                      input logic [WIDTH-1:0] a_di,
                      input logic b_en, input logic b_we, input logic [DEPTH-1:0] b_addr,
                      input logic [WIDTH-1:0] b_di);
    rst   = r;
    ena   = a_en;  wea = a_we;  addra = a_addr;  dia = a_di;
    enb   = b_en;  web = b_we;  addrb = b_addr;  dib = b_di;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with idle ports
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_doa[%0d]", i), doa_w[i], 32'h0);
      chk($sformatf("reset_dob[%0d]", i), dob_w[i], 32'h0);
    end

    // Port A write addr1, write addr2, read addr2
    step(1'b0, 1'b1, 1'b1, 4'd1, 32'h11223344, 1'b0, 1'b0, '0, '0);
    chk("wr1_wf_doa0", doa_w[0], 32'h11223344);
    step(1'b0, 1'b1, 1'b1, 4'd2, 32'h55667788, 1'b0, 1'b0, '0, '0);
    chk("wr1_lat2_doa2", doa_w[2], 32'h11223344);
    chk("wr2_wf_doa0", doa_w[0], 32'h55667788);
    step(1'b0, 1'b1, 1'b0, 4'd2, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("wr2_lat2_doa2", doa_w[2], 32'h55667788);

    // Hold: ena=0 with a would-be write to addr2 for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd2, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
      chk($sformatf("hold_doa2_c%0d", i), doa_w[2], 32'h55667788);
      chk($sformatf("hold_doa0_c%0d", i), doa_w[0], 32'h55667788);
    end
    step(1'b0, 1'b1, 1'b0, 4'd2, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("hold_mem_unchanged", doa_w[0], 32'h55667788);

    // Cross-port: B writes addr2 while A reads addr2
    step(1'b0, 1'b1, 1'b0, 4'd2, 32'h0, 1'b1, 1'b1, 4'd2, 32'hCAFEDECA);
    chk("xb_dob2", dob_w[2], 32'hCAFEDECA);
    chk("xb_bypass_doa0", doa_w[0], 32'hCAFEDECA);
    chk("xb_old_doa2", doa_w[2], 32'h55667788);
    idle();
    chk("xb_lat2_doa2", doa_w[2], 32'hCAFEDECA);
    chk("xb_lat2_dob3", dob_w[3], 32'hCAFEDECA);

    // Cross-port: A writes addr3 while B reads addr3
    step(1'b0, 1'b1, 1'b1, 4'd3, 32'h12345678, 1'b1, 1'b0, 4'd3, 32'h0);
    chk("xa_bypass_dob0", dob_w[0], 32'h12345678);

    // Dual write to addr5: B data wins on both ports
    step(1'b0, 1'b1, 1'b1, 4'd5, 32'hAAAA0000, 1'b1, 1'b1, 4'd5, 32'hBBBB0000);
    chk("dw_doa0", doa_w[0], 32'hBBBB0000);
    chk("dw_dob0", dob_w[0], 32'hBBBB0000);
    step(1'b0, 1'b1, 1'b0, 4'd5, 32'h0, 1'b1, 1'b0, 4'd5, 32'h0);
    chk("dw_rd_doa0", doa_w[0], 32'hBBBB0000);
    chk("dw_rd_dob0", dob_w[0], 32'hBBBB0000);
    chk("dw_lat2_doa3", doa_w[3], 32'hBBBB0000);
    chk("dw_lat2_dob3", dob_w[3], 32'hBBBB0000);

    // Reset mid-read; B's write to addr6 during reset still lands
    step(1'b1, 1'b1, 1'b0, 4'd1, 32'h0, 1'b1, 1'b1, 4'd6, 32'h66666666);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_doa[%0d]", i), doa_w[i], 32'h0);
      chk($sformatf("rst_dob[%0d]", i), dob_w[i], 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 4'd1, 32'h0, 1'b1, 1'b0, 4'd6, 32'h0);
    chk("post_rst_doa0", doa_w[0], 32'h11223344);
    chk("post_rst_dob0", dob_w[0], 32'h66666666);
    chk("post_rst_endly_doa3", doa_w[3], 32'h0);
    idle();
    chk("post_rst_lat2_doa3", doa_w[3], 32'h11223344);
    chk("post_rst_lat2_dob3", dob_w[3], 32'h66666666);

    // Top address and latency sweep across the four configurations
    step(1'b0, 1'b1, 1'b1, 4'd15, 32'h0F0F0F0F, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd15, 32'h0);
    chk("top_dob0", dob_w[0], 32'h0F0F0F0F);
    chk("addr0_zero_doa0", doa_w[0], 32'h0);
    chk("lat_b_not_early_dob1", dob_w[1], 32'h66666666);
    idle();
    chk("lat_b_dob1", dob_w[1], 32'h0F0F0F0F);
    chk("lat_b_dob2", dob_w[2], 32'h0F0F0F0F);
    step(1'b0, 1'b1, 1'b0, 4'd15, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("top_doa0", doa_w[0], 32'h0F0F0F0F);
    chk("top_doa1", doa_w[1], 32'h0F0F0F0F);
    chk("lat_a_not_early_doa2", doa_w[2], 32'h0);
    idle();
    chk("lat_a_doa2", doa_w[2], 32'h0F0F0F0F);
    chk("lat_a_doa3", doa_w[3], 32'h0F0F0F0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
